// File: rtl/riscv_mem_ctrl.sv
// riscv_mem_ctrl: RV32I load/store unit in front of a word-wide, 1024-deep memory.
// Byte addresses become word addresses, and sub-word loads are sign- or zero-extended.
// Sub-word stores are done as read-modify-write.
// Misaligned or illegal accesses complete with err and never touch memory.
module riscv_mem_ctrl #(
    parameter int unsigned READ_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic [9:0]  address,
    output logic [31:0] data,
    output logic        rden,
    output logic        wren,
    input  logic [31:0] readout
);

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t      state, state_nxt;
    logic [2:0]  cnt;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic [31:0] wdata_q;
    logic [31:0] word_q;
    logic        err_q;
    logic        legal, misaligned, bad, rd_last;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_ext;
    logic [31:0] merged;
    logic        unused_addr_hi;

    assign unused_addr_hi = ^addr[31:12];

    // Legality and alignment of the incoming request
    always_comb begin
        if (we)
            legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
        else
            legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                    (funct3 == 3'b100) || (funct3 == 3'b101);
        misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                     ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
        bad = !legal || misaligned;
    end

    assign rd_last = (cnt == 3'(READ_LAT - 1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (req) begin
                if (bad)                          state_nxt = DONE;
                else if (we && funct3 == 3'b010)  state_nxt = WR;
                else                              state_nxt = RD;
            end
            RD:   if (rd_last) state_nxt = we_q ? WR : DONE;
            WR:   state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request latch, read-latency counter, captured word and load result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            we_q    <= 1'b0;
            f3_q    <= '0;
            off_q   <= '0;
            address <= '0;
            wdata_q <= '0;
            word_q  <= '0;
            err_q   <= 1'b0;
            rdata   <= '0;
        end else begin
            if (state == IDLE && req) begin
                we_q    <= we;
                f3_q    <= funct3;
                off_q   <= addr[1:0];
                address <= addr[11:2];
                wdata_q <= wdata;
                err_q   <= bad;
            end
            if (state == RD) begin
                cnt <= rd_last ? '0 : cnt + 3'd1;
                if (rd_last) begin
                    word_q <= readout;
                    if (!we_q) rdata <= load_ext;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    // Lane selection and extension of the memory word for loads
    always_comb begin
        case (off_q)
            2'd0:    byte_sel = readout[7:0];
            2'd1:    byte_sel = readout[15:8];
            2'd2:    byte_sel = readout[23:16];
            default: byte_sel = readout[31:24];
        endcase
        half_sel = off_q[1] ? readout[31:16] : readout[15:0];
        case (f3_q)
            3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
            3'b100:  load_ext = {24'd0, byte_sel};
            3'b101:  load_ext = {16'd0, half_sel};
            default: load_ext = readout;
        endcase
    end

    // Store data: SW passes wdata through, SB/SH replace one lane of the captured word
    always_comb begin
        merged = word_q;
        case (f3_q[1:0])
            2'b00: case (off_q)
                2'd0:    merged[7:0]   = wdata_q[7:0];
                2'd1:    merged[15:8]  = wdata_q[7:0];
                2'd2:    merged[23:16] = wdata_q[7:0];
                default: merged[31:24] = wdata_q[7:0];
            endcase
            2'b01: if (off_q[1]) merged[31:16] = wdata_q[15:0];
                   else          merged[15:0]  = wdata_q[15:0];
            default: merged = wdata_q;
        endcase
    end

    // Outputs decoded from state so reset drops them without a clock edge
    always_comb begin
        busy = (state != IDLE);
        rden = (state == RD);
        wren = (state == WR);
        done = (state == DONE);
        err  = (state == DONE) && err_q;
        data = (state == WR) ? merged : '0;
    end

endmodule
